pipelined_carry_adder: RTL



---
 rtl/pipelined_carry_adder_if.sv | 44 ++++
 rtl/pipelined_carry_adder.sv | 111 +++++++++++
 2 files changed

// File: rtl/pipelined_carry_adder_if.sv
// Operand/result bus of pipelined_carry_adder.
// Optional feature macro: PIPELINED_CARRY_ADDER_SUB_EN adds the 'sub' request bit.
//
// Handshake: on each side a beat transfers on a rising clock edge where
// valid && ready are both high. A producer holds its data stable while
// valid is high and ready is low. ready may depend on the consumer's
// state but never on the same side's valid.
interface pipelined_carry_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

    // Adder side: takes operands, produces results.
    modport slave (
        input  in_valid, a, b, carryin,
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, carryout, overflow
    );

    // Client side: supplies operands, consumes results.
    modport master (
        output in_valid, a, b, carryin,
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, carryout, overflow
    );
endinterface

// File: rtl/pipelined_carry_adder.sv
// Pipelined WIDTH-bit adder: NSTAGES slices of STAGE_BITS each, one register
// stage per slice, carry passed between slices through registers.
// Optional feature macro: PIPELINED_CARRY_ADDER_SUB_EN (a - b mode via bus.sub).
//
// Slot k holds the sum bits computed so far (bits above slice k are don't-care),
// the carry out of slice k, and the full operand words so later slices can
// pick their bits. The B word is stored already inverted for subtraction, so
// the 'sub' request travels with its operands implicitly.
// The whole pipeline advances together when the output slot is empty or is
// being taken; otherwise everything holds.
module pipelined_carry_adder #(
    parameter int WIDTH      = 32,
    parameter int STAGE_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    pipelined_carry_adder_if.slave  bus
);
    localparam int NSTAGES = WIDTH / STAGE_BITS;
    localparam int SB      = STAGE_BITS;

    logic                adv;
    logic [WIDTH-1:0]    b_eff;
    logic                cin_eff;

    logic [NSTAGES-1:0]  valid_q;
    logic [NSTAGES-1:0]  valid_d;
    logic [NSTAGES-1:0]  carry_q;
    logic [NSTAGES-1:0]  carry_d;
    logic [WIDTH-1:0]    a_q   [NSTAGES];
    logic [WIDTH-1:0]    b_q   [NSTAGES];
    logic [WIDTH-1:0]    sum_q [NSTAGES];
    logic [WIDTH-1:0]    sum_d [NSTAGES];
    logic                ovf_q;
    logic                ovf_d;

    // Inputs seen by each slice: slice 0 from the bus, slice k from slot k-1.
    logic [WIDTH-1:0]    src_a   [NSTAGES];
    logic [WIDTH-1:0]    src_b   [NSTAGES];
    logic [WIDTH-1:0]    src_sum [NSTAGES];
    logic [NSTAGES-1:0]  src_c;
    logic [SB:0]         slice_r [NSTAGES];

    assign adv = !valid_q[NSTAGES-1] || bus.out_ready;

    // Effective B operand and bit-0 carry (subtract = add inverted B plus one).
    always_comb begin
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
        b_eff   = bus.sub ? ~bus.b : bus.b;
        cin_eff = bus.sub ? 1'b1 : bus.carryin;
`else
        b_eff   = bus.b;
        cin_eff = bus.carryin;
`endif
    end

    // Route each slice's operands, partial sum, carry-in and valid.
    always_comb begin
        src_a[0]   = bus.a;
        src_b[0]   = b_eff;
        src_sum[0] = '0;
        src_c[0]   = cin_eff;
        valid_d[0] = bus.in_valid;
        for (int k = 1; k < NSTAGES; k++) begin
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_c[k]   = carry_q[k-1];
            valid_d[k] = valid_q[k-1];
        end
    end

    // Per-slice STAGE_BITS add; the last slice also forms signed overflow.
    always_comb begin
        for (int k = 0; k < NSTAGES; k++) begin
            slice_r[k] = {1'b0, src_a[k][k*SB +: SB]}
                       + {1'b0, src_b[k][k*SB +: SB]}
                       + {{SB{1'b0}}, src_c[k]};
            sum_d[k]   = src_sum[k];
            sum_d[k][k*SB +: SB] = slice_r[k][SB-1:0];
            carry_d[k] = slice_r[k][SB];
        end
        ovf_d = (src_a[NSTAGES-1][WIDTH-1] == src_b[NSTAGES-1][WIDTH-1])
             && (slice_r[NSTAGES-1][SB-1] != src_a[NSTAGES-1][WIDTH-1]);
    end

    // Pipeline registers: reset clears valids and the output slot, adv shifts all.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q              <= '0;
            carry_q              <= '0;
            sum_q[NSTAGES-1]     <= '0;
            ovf_q                <= 1'b0;
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < NSTAGES; k++) begin
                a_q[k]   <= src_a[k];
                b_q[k]   <= src_b[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = valid_q[NSTAGES-1];
    assign bus.sum       = sum_q[NSTAGES-1];
    assign bus.carryout  = carry_q[NSTAGES-1];
    assign bus.overflow  = ovf_q;
endmodule
